// File: rtl/output_row_packer_pkg.sv
// Shared accelerator package: packer FSM state type and default element/word widths.
package output_row_packer_pkg;

    localparam int unsigned PKR_ELEM_W = 32'd32;
    localparam int unsigned PKR_BW_OUT = 32'd128;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } packer_state_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream interface with byte strobes, as used across the accelerator datapath.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32'd32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 32'd8
);

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/output_row_packer.sv
// Packs engine result elements into BW_OUT-wide words, closing a word when full or on end-of-row.
module output_row_packer
    import output_row_packer_pkg::*;
#(
    parameter int unsigned ELEM_W = PKR_ELEM_W,
    parameter int unsigned BW_OUT = PKR_BW_OUT
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    input logic                    clear_i,
    hwpe_stream_intf_stream.sink   stream_i,
    input logic                    last_i,
    hwpe_stream_intf_stream.source stream_o
);

    localparam int unsigned N_ELEM  = BW_OUT / ELEM_W;
    localparam int unsigned CNT_W   = $clog2(N_ELEM) + 32'd1;
    localparam int unsigned ESTRB_W = ELEM_W / 32'd8;
    localparam int unsigned OSTRB_W = BW_OUT / 32'd8;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_ELEM - 32'd1);

    if ((BW_OUT % ELEM_W) != 32'd0) begin : g_bad_width
        $error("output_row_packer: BW_OUT must be an integer multiple of ELEM_W");
    end

    packer_state_t        state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [BW_OUT-1:0]    buffer_r, buffer_s;
    logic [OSTRB_W-1:0]   strb_r, strb_s;
    logic                 in_ready_s;
    logic                 in_hs_s;
    logic                 out_hs_s;

    // In DRAIN the input is only accepted when the current word leaves in the same cycle.
    assign in_ready_s      = (state_r == FILL) ? 1'b1 : stream_o.ready;
    assign in_hs_s         = stream_i.valid & in_ready_s;
    assign out_hs_s        = (state_r == DRAIN) & stream_o.ready;

    assign stream_i.ready  = in_ready_s;
    assign stream_o.valid  = (state_r == DRAIN);
    assign stream_o.data   = buffer_r;
    assign stream_o.strb   = strb_r;

    // Next-state, slot counter and buffer update.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        buffer_s = buffer_r;
        strb_s   = strb_r;
        case (state_r)
            FILL: begin
                if (in_hs_s) begin
                    buffer_s[cnt_r*ELEM_W +: ELEM_W] = stream_i.data;
                    strb_s[cnt_r*ESTRB_W +: ESTRB_W] = stream_i.strb;
                    if ((cnt_r == LAST_SLOT) || last_i) begin
                        state_s = DRAIN;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = FILL;
                end
            end
            DRAIN: begin
                if (out_hs_s) begin
                    buffer_s = '0;
                    strb_s   = '0;
                    cnt_s    = '0;
                    if (in_hs_s) begin
                        // Back-to-back: the new element starts the next word in slot 0.
                        buffer_s[ELEM_W-1:0]  = stream_i.data;
                        strb_s[ESTRB_W-1:0]   = stream_i.strb;
                        if ((N_ELEM == 32'd1) || last_i) begin
                            state_s = DRAIN;
                        end else begin
                            state_s = FILL;
                            cnt_s   = CNT_W'(1);
                        end
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s  = FILL;
                cnt_s    = '0;
                buffer_s = '0;
                strb_s   = '0;
            end
        endcase
    end

    // State and datapath registers; clear discards any pending word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= FILL;
            cnt_r    <= '0;
            buffer_r <= '0;
            strb_r   <= '0;
        end else if (clear_i) begin
            state_r  <= FILL;
            cnt_r    <= '0;
            buffer_r <= '0;
            strb_r   <= '0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            buffer_r <= buffer_s;
            strb_r   <= strb_s;
        end
    end

endmodule

// File: tb/tb_output_row_packer.sv
// Randomized and directed bench for output_row_packer against a queue-based word model.
module tb_output_row_packer;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  s;
    } word_t;

    logic clk;
    logic rst_ni;
    logic clear_i;
    logic last_i;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32))  in_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(128)) out_if ();

    output_row_packer #(.ELEM_W(32), .BW_OUT(128)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .stream_i (in_if),
        .last_i   (last_i),
        .stream_o (out_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    word_t        exp_q[$];
    int           grp_n = 0;
    logic [127:0] grp_d = '0;
    logic [15:0]  grp_s = '0;
    bit           stall_q = 0;
    logic [127:0] prev_d;
    logic [15:0]  prev_s;
    logic [127:0] last_word;
    logic [15:0]  last_strb;
    int           words_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference model: elements are grouped four to a word or up to an end-of-row flag.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            grp_n = 0; grp_d = '0; grp_s = '0; stall_q = 0;
            check("rst_valid", out_if.valid, 1'b0);
            check("rst_in_ready", in_if.ready, 1'b1);
            check("rst_data", out_if.data, 128'd0);
            check("rst_strb", out_if.strb, 16'd0);
        end else begin
            check("valid", out_if.valid, exp_q.size() != 0);
            check("in_ready", in_if.ready, (exp_q.size() == 0) || out_if.ready);
            if (stall_q && out_if.valid) begin
                check("hold_data", out_if.data, prev_d);
                check("hold_strb", out_if.strb, prev_s);
            end
            if (clear_i) begin
                exp_q.delete();
                grp_n = 0; grp_d = '0; grp_s = '0; stall_q = 0;
            end else begin
                stall_q = out_if.valid && !out_if.ready;
                prev_d  = out_if.data;
                prev_s  = out_if.strb;
                if (out_if.valid && out_if.ready && exp_q.size() != 0) begin
                    check("word_data", out_if.data, exp_q[0].d);
                    check("word_strb", out_if.strb, exp_q[0].s);
                    void'(exp_q.pop_front());
                    last_word = out_if.data;
                    last_strb = out_if.strb;
                    words_seen++;
                end
                if (in_if.valid && in_if.ready) begin
                    grp_d = grp_d | ({96'd0, in_if.data} << (32 * grp_n));
                    grp_s = grp_s | ({12'd0, in_if.strb} << (4 * grp_n));
                    grp_n++;
                    if (grp_n == 4 || last_i) begin
                        exp_q.push_back('{d: grp_d, s: grp_s});
                        grp_n = 0; grp_d = '0; grp_s = '0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l);
        bit ok;
        ok = 0;
        in_if.valid = 1'b1; in_if.data = d; in_if.strb = s; last_i = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_if.ready;
            @(posedge clk); #1;
        end
        in_if.valid = 1'b0; last_i = 1'b0;
        if (!ok) check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_word(input int n, input string tag);
        for (int i = 0; i < 20 && words_seen == n; i++) @(posedge clk);
        #1;
        check(tag, words_seen != n, 1'b1);
    endtask

    initial begin
        int n0, c0;
        rst_ni = 1'b0; clear_i = 1'b0; last_i = 1'b0;
        in_if.valid = 1'b0; in_if.data = '0; in_if.strb = '0;
        out_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk); #1;

        // Four full elements, last on the fourth
        n0 = words_seen;
        send(32'h11, 4'hF, 1'b0); send(32'h22, 4'hF, 1'b0);
        send(32'h33, 4'hF, 1'b0); send(32'h44, 4'hF, 1'b1);
        check("lat_valid", out_if.valid, 1'b1);
        wait_word(n0, "w4_timeout");
        check("w4_data", last_word, 128'h00000044_00000033_00000022_00000011);
        check("w4_strb", last_strb, 16'hFFFF);

        // Partial word on early last
        n0 = words_seen;
        send(32'hA, 4'hF, 1'b0); send(32'hB, 4'hF, 1'b1);
        wait_word(n0, "w2_timeout");
        check("w2_data", last_word, 128'h0000000B_0000000A);
        check("w2_strb", last_strb, 16'h00FF);

        // Output stall in DRAIN with an element waiting
        out_if.ready = 1'b0;
        send(32'h1, 4'hF, 1'b0); send(32'h2, 4'h3, 1'b0);
        send(32'h3, 4'h0, 1'b0); send(32'h4, 4'hF, 1'b0);
        in_if.valid = 1'b1; in_if.data = 32'h55; in_if.strb = 4'hF; last_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_if.valid, 1'b1);
            check("stall_in_ready", in_if.ready, 1'b0);
        end
        @(posedge clk); #1;
        out_if.ready = 1'b1;
        n0 = words_seen;
        send(32'h55, 4'hF, 1'b1);
        check("stall_word", last_word, 128'h00000004_00000003_00000002_00000001);
        check("stall_strb", last_strb, 16'hF03F);
        wait_word(n0 + 1, "stall_next_timeout");
        check("stall_next", last_word, 128'h55);

        // Continuous eight-element stream
        n0 = words_seen;
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(32'h100 + i, 4'hF, (i % 4) == 3);
        check("stream_cycles", cyc - c0, 8);
        repeat (2) @(posedge clk); #1;
        check("stream_words", words_seen - n0, 2);

        // Clear after two elements
        send(32'hDEAD0001, 4'hF, 1'b0); send(32'hDEAD0002, 4'hF, 1'b0);
        clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
        n0 = words_seen;
        send(32'hC1, 4'hF, 1'b0); send(32'hC2, 4'hF, 1'b0);
        send(32'hC3, 4'hF, 1'b0); send(32'hC4, 4'hF, 1'b1);
        wait_word(n0, "clr_timeout");
        check("clr_data", last_word, 128'h000000C4_000000C3_000000C2_000000C1);
        check("clr_strb", last_strb, 16'hFFFF);

        // Asynchronous reset while a word is pending
        out_if.ready = 1'b0;
        send(32'h7, 4'hF, 1'b0); send(32'h8, 4'hF, 1'b1);
        @(negedge clk); #2 rst_ni = 1'b0;
        #1;
        check("async_valid", out_if.valid, 1'b0);
        check("async_data", out_if.data, 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1; out_if.ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_if.ready, 1'b1);
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_if.valid  = ($urandom_range(0, 9) < 7);
            in_if.data   = $urandom;
            in_if.strb   = 4'($urandom_range(0, 15));
            last_i       = ($urandom_range(0, 4) == 0);
            out_if.ready = ($urandom_range(0, 9) < 7);
            clear_i      = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end
        in_if.valid = 1'b0; last_i = 1'b0; clear_i = 1'b0; out_if.ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
